byte_unstriping: RTL and testbench
==================================

Name: byte_unstriping

Overview:
Receive-side counterpart of the 4-lane transmitter: consumes one 4-lane symbol word per handshake (lane0..lane3 bytes plus per-lane K flags) and re-serialises it into one byte per clock in lane order 0,1,2,3. Buffers up to two words, drops SKP ordered-set symbols, and runs a packet-framing checker on the re-serialised stream (STP/SDP open, END/EDB close). Output feeds the receive-side demux/link layer.

Parameters:
BUF_DEPTH, 2, word buffer entries (fixed at 2; other values unsupported)
ERR_W, 8, width of saturating framing-error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
enb  input  1  global enable; low freezes all state
rx_lane0  input  8  lane 0 byte of the word (first in byte order)
rx_lane1  input  8  lane 1 byte
rx_lane2  input  8  lane 2 byte
rx_lane3  input  8  lane 3 byte (last in byte order)
rx_k  input  4  bit i = 1: lane i byte is a K (control) symbol
rx_valid  input  1  word present on lanes
rx_ready  output  1  buffer can accept a word this cycle
rx_DataS  output  8  re-serialised byte
rx_k_out  output  1  rx_DataS is a K symbol
rx_out_valid  output  1  rx_DataS/rx_k_out valid this cycle
pkt_start  output  1  1-cycle pulse with an STP/SDP byte
pkt_end  output  1  1-cycle pulse with an END/EDB byte
pkt_bad  output  1  1-cycle pulse with EDB (nullified packet)
in_pkt  output  1  framing FSM in IN_PKT
frame_err  output  1  1-cycle pulse on a framing violation
err_cnt  output  ERR_W  saturating count of frame_err pulses

Behaviour:
- Reset (async, rst=1): buffer empty, byte index 0, FSM IDLE; rx_DataS=8'h00, rx_k_out=0, rx_out_valid=0, all pulses 0, in_pkt=0, err_cnt=0. rx_ready=0 while rst=1.
- rx_ready = enb & (count < 2), combinational from registered count. Word is written when rx_valid & rx_ready; rx_valid with rx_ready=0 is ignored (sender holds).
- Drain: with enb=1 and count>0, each cycle selects head-word byte idx (0..3), idx increments; at idx=3 head pops, idx returns to 0. Simultaneous push and pop in the same cycle allowed; count unchanged.
- Latency: word accepted at edge N -> lane0 byte registered on outputs after edge N+1, lane3 after N+4. Back-to-back words give gapless output (minus dropped SKPs).
- SKP (K, 8'h1C): consumed, rx_out_valid=0 that cycle, no FSM effect. All other bytes: rx_out_valid=1.
- Framing FSM, evaluated on each emitted byte:
  IDLE: K STP(FB)/SDP(5C) -> pkt_start, go IN_PKT. K COM(BC)/IDLE(7C)/FTS(3C) -> stay. K END(FD)/EDB(FE) -> frame_err. Data byte (K=0) -> frame_err. Any other K value -> frame_err.
  IN_PKT: data -> stay. K END -> pkt_end, go IDLE. K EDB -> pkt_end + pkt_bad, go IDLE. K STP/SDP -> frame_err + pkt_start, stay IN_PKT (restart). K COM/IDLE/FTS or unknown K -> frame_err, go IDLE.
- Pulses are registered, aligned with the byte that caused them; cleared next cycle.
- err_cnt increments on each frame_err; saturates at all-ones, no wrap.
- enb=0: no push, no pop, idx/FSM/err_cnt hold; rx_out_valid and all pulses forced 0; rx_DataS/rx_k_out hold last value; in_pkt holds.
- Reset mid-packet: buffer flushed, FSM to IDLE, no pkt_end generated.

Decomposition:
- Shared package/header: K-code constants COM=BC, SKP=1C, STP=FB, SDP=5C, END=FD, EDB=FE, FTS=3C, IDLE=7C (same values the transmitter uses); FSM state encodings IDLE/IN_PKT.
- One sub-module: unstripe_buf (2-entry 36-bit word FIFO: 4x8 data + 4 K bits, with count, push/pop, head output). Serialiser, SKP filter and framing FSM stay in the top.

Test Plan:
- Reset then word {FB,11,22,FD}, rx_k=1001 -> outputs FB/k=1 + pkt_start, 11, 22, FD/k=1 + pkt_end on 4 consecutive cycles starting 1 cycle after accept; in_pkt 1 for cycles 1-3; err_cnt=0.
- Three back-to-back words with rx_valid held high -> rx_ready drops after 2nd accept, 3rd accepted only after the first pop; 12 output bytes gapless, order preserved.
- Word {BC,1C,1C,1C}, k=1111 -> one valid BC byte, then 3 cycles rx_out_valid=0; no pulses.
- Word {FD,AA,5C,FE}, k=1011 from IDLE -> frame_err on FD, frame_err on AA, pkt_start on 5C, pkt_end+pkt_bad on FE; err_cnt=2.
- enb=0 for 3 cycles mid-word (after byte 1) -> outputs hold, rx_out_valid=0, rx_ready=0; byte 2 emitted the first cycle after enb=1.
- rst pulsed while in IN_PKT with one word buffered -> all outputs 0 immediately (async), buffer empty, no pkt_end; next STP word yields a normal pkt_start.

Source files
------------

// File: rtl/byte_unstriping_pkg.sv
// Shared symbol codes, framing states and word layout for the 4-lane receive path.
package byte_unstriping_pkg;

    // K-code values, identical to the ones the transmitter emits
    localparam logic [7:0] K_COM  = 8'hBC;
    localparam logic [7:0] K_SKP  = 8'h1C;
    localparam logic [7:0] K_STP  = 8'hFB;
    localparam logic [7:0] K_SDP  = 8'h5C;
    localparam logic [7:0] K_END  = 8'hFD;
    localparam logic [7:0] K_EDB  = 8'hFE;
    localparam logic [7:0] K_FTS  = 8'h3C;
    localparam logic [7:0] K_IDLE = 8'h7C;

    localparam int unsigned LANES  = 4;
    localparam int unsigned WORD_W = LANES * 8 + LANES;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_state_t;

    // Buffered symbol word: K flags on top, lane 3 .. lane 0 below
    typedef struct packed {
        logic [LANES-1:0]      k;
        logic [LANES-1:0][7:0] lane;
    } sym_word_t;

    function automatic logic is_fill_k(input logic [7:0] b);
        return (b == K_COM) || (b == K_IDLE) || (b == K_FTS);
    endfunction

endpackage

// File: rtl/unstripe_buf.sv
// Two-entry word FIFO holding lane bytes plus K flags; head is visible without popping.
module unstripe_buf
    import byte_unstriping_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [WORD_W-1:0]   wdata_i,
    output logic [WORD_W-1:0]   head_o,
    output logic [1:0]          count_o
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [WORD_W-1:0] mem_q [0:1];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    // Pointer and occupancy update; push and pop in one cycle keep the count
    always_comb begin
        do_push  = push_i && (count_q < DEPTH_C);
        do_pop   = pop_i && (count_q != 2'd0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ~wr_ptr_q;
        if (do_pop)  rd_ptr_d = ~rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/byte_unstriping.sv
// Receive-side 4-lane to byte serialiser with SKP removal and packet framing check.
module byte_unstriping
    import byte_unstriping_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [7:0]       rx_lane0,
    input  logic [7:0]       rx_lane1,
    input  logic [7:0]       rx_lane2,
    input  logic [7:0]       rx_lane3,
    input  logic [3:0]       rx_k,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       rx_DataS,
    output logic             rx_k_out,
    output logic             rx_out_valid,
    output logic             pkt_start,
    output logic             pkt_end,
    output logic             pkt_bad,
    output logic             in_pkt,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] BUF_CNT = 2'(BUF_DEPTH);

    sym_word_t         wr_word, head;
    logic [WORD_W-1:0] head_w;
    logic [1:0]        count;
    logic              push, pop, have_word;
    logic [7:0]        byte_sel;
    logic              k_sel;

    frame_state_t      state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        data_q, data_d;
    logic              kout_q, kout_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              end_q, end_d;
    logic              bad_q, bad_d;
    logic              ferr_q, ferr_d;
    logic [ERR_W-1:0]  err_q, err_d;

    assign wr_word.k    = rx_k;
    assign wr_word.lane = {rx_lane3, rx_lane2, rx_lane1, rx_lane0};

    assign have_word = (count != 2'd0);
    assign rx_ready  = enb && !rst && (count < BUF_CNT);
    assign push      = rx_valid && rx_ready;
    assign pop       = enb && have_word && (idx_q == 2'd3);

    unstripe_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_word),
        .head_o  (head_w),
        .count_o (count)
    );

    assign head     = sym_word_t'(head_w);
    assign byte_sel = head.lane[idx_q];
    assign k_sel    = head.k[idx_q];

    // Byte selection, SKP drop and framing decisions for the byte leaving this cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        kout_d  = kout_q;
        valid_d = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;
        bad_d   = 1'b0;
        ferr_d  = 1'b0;
        err_d   = err_q;
        if (enb && have_word) begin
            idx_d = idx_q + 2'd1;
            if (!(k_sel && (byte_sel == K_SKP))) begin
                data_d  = byte_sel;
                kout_d  = k_sel;
                valid_d = 1'b1;
                unique case (state_q)
                    ST_IDLE: begin
                        if (k_sel && ((byte_sel == K_STP) || (byte_sel == K_SDP))) begin
                            start_d = 1'b1;
                            state_d = ST_IN_PKT;
                        end else if (!(k_sel && is_fill_k(byte_sel))) begin
                            ferr_d = 1'b1;
                        end
                    end
                    ST_IN_PKT: begin
                        if (!k_sel) begin
                            state_d = ST_IN_PKT;
                        end else if (byte_sel == K_END) begin
                            end_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else if (byte_sel == K_EDB) begin
                            end_d   = 1'b1;
                            bad_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else if ((byte_sel == K_STP) || (byte_sel == K_SDP)) begin
                            ferr_d  = 1'b1;
                            start_d = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
        if (ferr_d && (err_q != '1)) err_d = err_q + 1'b1;
    end

    // Output, index, framing state and error counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            kout_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            bad_q   <= 1'b0;
            ferr_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            kout_q  <= kout_d;
            valid_q <= valid_d;
            start_q <= start_d;
            end_q   <= end_d;
            bad_q   <= bad_d;
            ferr_q  <= ferr_d;
            err_q   <= err_d;
        end
    end

    assign rx_DataS     = data_q;
    assign rx_k_out     = kout_q;
    assign rx_out_valid = valid_q;
    assign pkt_start    = start_q;
    assign pkt_end      = end_q;
    assign pkt_bad      = bad_q;
    assign in_pkt       = (state_q == ST_IN_PKT);
    assign frame_err    = ferr_q;
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: ordering, latency, SKP drop, framing, enable and reset.
module tb_byte_unstriping;

    logic       clk = 1'b0;
    logic       rst, enb;
    logic [7:0] rx_lane0, rx_lane1, rx_lane2, rx_lane3;
    logic [3:0] rx_k;
    logic       rx_valid, rx_ready;
    logic [7:0] rx_DataS;
    logic       rx_k_out, rx_out_valid, pkt_start, pkt_end, pkt_bad, in_pkt, frame_err;
    logic [7:0] err_cnt;

    byte_unstriping #(
        .BUF_DEPTH (2),
        .ERR_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .rx_lane0     (rx_lane0),
        .rx_lane1     (rx_lane1),
        .rx_lane2     (rx_lane2),
        .rx_lane3     (rx_lane3),
        .rx_k         (rx_k),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_DataS     (rx_DataS),
        .rx_k_out     (rx_k_out),
        .rx_out_valid (rx_out_valid),
        .pkt_start    (pkt_start),
        .pkt_end      (pkt_end),
        .pkt_bad      (pkt_bad),
        .in_pkt       (in_pkt),
        .frame_err    (frame_err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        k, st, en, bd, fe, ip;
        int unsigned cyc;
    } out_rec_t;

    out_rec_t    recs[$];
    int unsigned cyc     = 0;
    int unsigned n_start = 0, n_end = 0, n_ferr = 0;
    int unsigned n_cmp   = 0, n_mis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_out_valid)
            recs.push_back('{d: rx_DataS, k: rx_k_out, st: pkt_start, en: pkt_end,
                             bd: pkt_bad, fe: frame_err, ip: in_pkt, cyc: cyc});
        if (pkt_start) n_start++;
        if (pkt_end)   n_end++;
        if (frame_err) n_ferr++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word at a negedge and hold it until the DUT takes it; acc = accepting edge
    task automatic push_word(input logic [7:0] l0, l1, l2, l3, input logic [3:0] k,
                             output int unsigned acc);
        int unsigned guard = 0;
        rx_lane0 = l0; rx_lane1 = l1; rx_lane2 = l2; rx_lane3 = l3; rx_k = k;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            acc = 0;
        end else begin
            acc = cyc + 1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_rec(input string tag, input int unsigned idx, input logic [7:0] d,
                             input logic k, st, en, bd, fe, ip, input int unsigned cy);
        if (idx < recs.size()) begin
            check_eq({tag, "_data"}, recs[idx].d, d);
            check_eq({tag, "_flags"}, {recs[idx].k, recs[idx].st, recs[idx].en,
                     recs[idx].bd, recs[idx].fe, recs[idx].ip}, {k, st, en, bd, fe, ip});
            check_eq({tag, "_cycle"}, recs[idx].cyc, cy);
        end else begin
            check_eq({tag, "_missing"}, idx, recs.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned a, b, c, base, s_start, s_end, s_ferr;
        logic [7:0] exp2 [12];
        rst = 1'b1; enb = 1'b1; rx_valid = 1'b0; rx_k = '0;
        rx_lane0 = '0; rx_lane1 = '0; rx_lane2 = '0; rx_lane3 = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", rx_ready, 1'b0);
        check_eq("rst_outs", {rx_DataS, rx_k_out, rx_out_valid, pkt_start, pkt_end,
                 pkt_bad, in_pkt, frame_err}, '0);
        check_eq("rst_errcnt", err_cnt, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", rx_ready, 1'b1);

        // Single packet in one word
        base = recs.size();
        push_word(8'hFB, 8'h11, 8'h22, 8'hFD, 4'b1001, a);
        repeat (5) @(negedge clk);
        check_eq("t1_count", recs.size() - base, 4);
        check_rec("t1_b0", base + 0, 8'hFB, 1, 1, 0, 0, 0, 1, a + 1);
        check_rec("t1_b1", base + 1, 8'h11, 0, 0, 0, 0, 0, 1, a + 2);
        check_rec("t1_b2", base + 2, 8'h22, 0, 0, 0, 0, 0, 1, a + 3);
        check_rec("t1_b3", base + 3, 8'hFD, 1, 0, 1, 0, 0, 0, a + 4);
        check_eq("t1_errcnt", err_cnt, 8'd0);

        // Three back-to-back words, backpressure after the second
        exp2 = '{8'hFB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                 8'h08, 8'h09, 8'h0A, 8'hFD};
        base = recs.size();
        push_word(8'hFB, 8'h01, 8'h02, 8'h03, 4'b0001, a);
        push_word(8'h04, 8'h05, 8'h06, 8'h07, 4'b0000, b);
        push_word(8'h08, 8'h09, 8'h0A, 8'hFD, 4'b1000, c);
        check_eq("t2_acc_b", b, a + 1);
        check_eq("t2_acc_c", c, a + 5);
        repeat (14) @(negedge clk);
        check_eq("t2_count", recs.size() - base, 12);
        for (int i = 0; i < 12; i++) begin
            if (base + i < recs.size()) begin
                check_eq($sformatf("t2_data%0d", i), recs[base + i].d, exp2[i]);
                check_eq($sformatf("t2_cyc%0d", i), recs[base + i].cyc, a + 1 + i);
            end
        end
        check_eq("t2_errcnt", err_cnt, 8'd0);

        // SKP symbols are dropped
        base = recs.size(); s_start = n_start; s_end = n_end; s_ferr = n_ferr;
        push_word(8'hBC, 8'h1C, 8'h1C, 8'h1C, 4'b1111, a);
        repeat (6) @(negedge clk);
        check_eq("t3_count", recs.size() - base, 1);
        check_rec("t3_com", base, 8'hBC, 1, 0, 0, 0, 0, 0, a + 1);
        check_eq("t3_pulses", (n_start - s_start) + (n_end - s_end) + (n_ferr - s_ferr), 0);

        // Framing errors from IDLE, then nullified packet
        base = recs.size();
        push_word(8'hFD, 8'hAA, 8'h5C, 8'hFE, 4'b1101, a);
        repeat (5) @(negedge clk);
        check_rec("t4_end", base + 0, 8'hFD, 1, 0, 0, 0, 1, 0, a + 1);
        check_rec("t4_data", base + 1, 8'hAA, 0, 0, 0, 0, 1, 0, a + 2);
        check_rec("t4_sdp", base + 2, 8'h5C, 1, 1, 0, 0, 0, 1, a + 3);
        check_rec("t4_edb", base + 3, 8'hFE, 1, 0, 1, 1, 0, 0, a + 4);
        check_eq("t4_errcnt", err_cnt, 8'd2);

        // Enable dropped for three cycles after byte 1
        push_word(8'hFB, 8'h33, 8'h44, 8'hFD, 4'b1001, a);
        @(negedge clk);
        check_eq("t5_b0", {rx_DataS, rx_out_valid}, {8'hFB, 1'b1});
        @(negedge clk);
        check_eq("t5_b1", {rx_DataS, rx_out_valid}, {8'h33, 1'b1});
        enb = 1'b0;
        #1 check_eq("t5_ready_off", rx_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("t5_hold%0d", i), {rx_DataS, rx_out_valid, in_pkt, rx_ready},
                     {8'h33, 1'b0, 1'b1, 1'b0});
        end
        enb = 1'b1;
        @(negedge clk);
        check_eq("t5_b2", {rx_DataS, rx_out_valid, cyc}, {8'h44, 1'b1, a + 6});
        @(negedge clk);
        check_eq("t5_b3", {rx_DataS, rx_out_valid, pkt_end}, {8'hFD, 1'b1, 1'b1});
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-packet with a word still buffered
        push_word(8'hFB, 8'h55, 8'h66, 8'h77, 4'b0001, a);
        push_word(8'h88, 8'h99, 8'hAA, 8'hBB, 4'b0000, b);
        check_eq("t6_inpkt", in_pkt, 1'b1);
        #2 rst = 1'b1;
        #1 check_eq("t6_rst_outs", {rx_DataS, rx_k_out, rx_out_valid, pkt_start, pkt_end,
                    pkt_bad, in_pkt, frame_err, rx_ready}, '0);
        check_eq("t6_rst_errcnt", err_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        base = recs.size(); s_end = n_end;
        repeat (5) @(negedge clk);
        check_eq("t6_flushed", recs.size() - base, 0);
        check_eq("t6_no_end", n_end - s_end, 0);
        push_word(8'hFB, 8'h01, 8'h02, 8'hFD, 4'b1001, a);
        repeat (5) @(negedge clk);
        check_rec("t6_restart", base, 8'hFB, 1, 1, 0, 0, 0, 1, a + 1);
        check_rec("t6_close", base + 3, 8'hFD, 1, 0, 1, 0, 0, 0, a + 4);
        check_eq("t6_errcnt", err_cnt, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
